// File: rtl/shift_pkg.sv
// shift_pkg: op encoding shared by the shift pipeline and its stages
package shift_pkg;
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_op_e;
endpackage

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage: conditional shift by STEP for one log-step of the pipeline (carry with SHIFT_PIPE_STATUS_EN)
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP = 1
) (
  input  logic             en,
  input  sh_op_e           op,
  input  logic             sign,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] shifted
`ifdef SHIFT_PIPE_STATUS_EN
  ,
  input  logic             carry,
  output logic             carry_next
`endif
);
  logic [STEP-1:0] fill;
  logic [WIDTH-1:0] shl, shr;
  // right shifts differ only in what enters the vacated MSBs
  always_comb begin
    fill = op == SH_SRA ? {STEP{sign}} : op == SH_ROR ? data[STEP-1:0] : '0;
    shl = {data[WIDTH-STEP-1:0], {STEP{1'b0}}};
    shr = {fill, data[WIDTH-1:STEP]};
    shifted = !en ? data : op == SH_SLL ? shl : shr;
  end
`ifdef SHIFT_PIPE_STATUS_EN
  // last bit leaving this step; for ROR it lands in the result MSB
  always_comb carry_next = !en ? carry : op == SH_SLL ? data[WIDTH-STEP] : data[STEP-1];
`endif
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter, one log-step per register, valid/ready with flush; SHIFT_PIPE_STATUS_EN adds out_zero/out_carry
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef SHIFT_PIPE_STATUS_EN
  ,
  output logic               out_zero,
  output logic               out_carry
`endif
);
  localparam int LAST = SHAMT_W - 1;
  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    sh_op_e             op;
    logic               sign;
`ifdef SHIFT_PIPE_STATUS_EN
    logic               carry;
`endif
  } payload_t;
  payload_t src [SHAMT_W];
  payload_t nxt [SHAMT_W];
  payload_t p [SHAMT_W];
  logic [WIDTH-1:0] shifted [SHAMT_W];
  logic [SHAMT_W-1:0] v, ld, take;
`ifdef SHIFT_PIPE_STATUS_EN
  logic carry_next [SHAMT_W];
  logic zero;
`endif
  // stage k works on the operand or on register k-1; its result replaces data (and carry)
  always_comb begin
    src[0].data = in_data;
    src[0].shamt = in_shamt;
    src[0].op = sh_op_e'(in_op);
    src[0].sign = in_data[WIDTH-1];
`ifdef SHIFT_PIPE_STATUS_EN
    src[0].carry = 1'b0;
`endif
    for (int k = 1; k < SHAMT_W; k++) src[k] = p[k-1];
    for (int k = 0; k < SHAMT_W; k++) begin
      nxt[k] = src[k];
      nxt[k].data = shifted[k];
`ifdef SHIFT_PIPE_STATUS_EN
      nxt[k].carry = carry_next[k];
`endif
    end
  end
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_pipe_stage #(.WIDTH(WIDTH), .STEP(1 << k)) u_stage (
      .en(src[k].shamt[k]),
      .op(src[k].op),
      .sign(src[k].sign),
      .data(src[k].data),
      .shifted(shifted[k])
`ifdef SHIFT_PIPE_STATUS_EN
      ,
      .carry(src[k].carry),
      .carry_next(carry_next[k])
`endif
    );
  end
  // a stage loads when it, or any stage after it, has room, or the consumer drains the last one
  always_comb begin
    for (int k = 0; k < SHAMT_W; k++) ld[k] = out_ready || |((~v) >> k);
  end
  assign in_ready = ld[0] && !flush;
  assign take = {v[SHAMT_W-2:0], in_valid && in_ready};
  // advance valids and payloads; flush empties every stage, data is only loaded for real entries
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      for (int k = 0; k < SHAMT_W; k++) p[k] <= '0;
`ifdef SHIFT_PIPE_STATUS_EN
      zero <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < SHAMT_W; k++) begin
        v[k] <= !flush && (ld[k] ? take[k] : v[k]);
        if (ld[k] && take[k]) p[k] <= nxt[k];
      end
`ifdef SHIFT_PIPE_STATUS_EN
      if (ld[LAST] && take[LAST]) zero <= nxt[LAST].data == '0;
`endif
    end
  end
  assign out_valid = v[LAST];
  assign out_data = p[LAST].data;
`ifdef SHIFT_PIPE_STATUS_EN
  assign out_zero = zero;
  assign out_carry = p[LAST].carry;
`endif
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: randomized and directed checks of shift_pipe against a queue-based reference model
module tb_shift_pipe;
  logic clock = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic [4:0] in_shamt = 0;
  logic [1:0] in_op = 0;
  logic in_ready, out_valid;
  logic [31:0] out_data;
  logic flush8 = 0, in8_valid = 0, out8_ready = 1;
  logic [7:0] in8_data = 0;
  logic [2:0] in8_shamt = 0;
  logic [1:0] in8_op = 0;
  logic in8_ready, out8_valid;
  logic [7:0] out8_data;
`ifdef SHIFT_PIPE_STATUS_EN
  logic out_zero, out_carry, out8_zero, out8_carry;
`endif
  typedef struct {
    logic [31:0] d;
    logic c;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, n_out = 0;

  shift_pipe u_dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SHIFT_PIPE_STATUS_EN
    , .out_zero(out_zero), .out_carry(out_carry)
`endif
  );
  shift_pipe #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .flush(flush8),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data), .in_shamt(in8_shamt), .in_op(in8_op),
    .out_valid(out8_valid), .out_ready(out8_ready), .out_data(out8_data)
`ifdef SHIFT_PIPE_STATUS_EN
    , .out_zero(out8_zero), .out_carry(out8_carry)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input int s, input logic [1:0] op, input int w);
    logic [63:0] x, m, r;
    exp_t e;
    m = (64'd1 << w) - 1;
    x = {32'd0, d} & m;
    case (op)
      2'd0: r = (x << s) & m;
      2'd1: r = x >> s;
      2'd2: r = (x >> s) | (x[w-1] ? (m & ~(m >> s)) : 64'd0);
      default: r = ((x >> s) | (x << (w - s))) & m;
    endcase
    e.d = r[31:0];
    e.c = s == 0 ? 1'b0 : op == 2'd0 ? x[w-s] : op == 2'd3 ? r[w-1] : x[s-1];
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset_n) q.delete();
    else begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", out_valid, 1'b0);
        else begin
          chk("data", out_data, q[0].d);
`ifdef SHIFT_PIPE_STATUS_EN
          chk("carry", out_carry, q[0].c);
          chk("zero", out_zero, q[0].d == 0);
`endif
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_data, in_shamt, in_op, 32));
    end
  end

  task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op, input logic [31:0] exp);
    int n;
    @(posedge clock); #1;
    in_valid = 1; in_data = d; in_shamt = s; in_op = op;
    @(negedge clock);
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clock); #1;
    in_valid = 0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < 40);
    chk({tag, "_lat"}, n, 5);
    chk(tag, out_data, exp);
  endtask

  task automatic run8(input string tag, input logic [7:0] d, input logic [2:0] s, input logic [1:0] op, input logic [31:0] exp, input logic c);
    int n;
    @(posedge clock); #1;
    in8_valid = 1; in8_data = d; in8_shamt = s; in8_op = op;
    @(negedge clock);
    chk({tag, "_rdy"}, in8_ready, 1);
    @(posedge clock); #1;
    in8_valid = 0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out8_valid && n < 40);
    chk({tag, "_lat"}, n, 3);
    chk(tag, {24'd0, out8_data}, exp);
`ifdef SHIFT_PIPE_STATUS_EN
    chk({tag, "_carry"}, out8_carry, c);
`else
    if (c === 1'bx) chk({tag, "_carry_x"}, c, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int b, n0, cnt;
    exp_t e;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid8", out8_valid, 0);
`ifdef SHIFT_PIPE_STATUS_EN
    chk("rst_zero", out_zero, 0);
    chk("rst_carry", out_carry, 0);
`endif
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    @(negedge clock);
    chk("rst_ready", in_ready, 1);

    run_one("sra_neg16", 32'h80000000, 16, 2'd2, 32'hFFFF8000);
    run_one("sra_pos16", 32'h12345678, 16, 2'd2, 32'h00001234);
    run_one("sll4", 32'hF000000F, 4, 2'd0, 32'h000000F0);
    run_one("srl4", 32'hF000000F, 4, 2'd1, 32'h0F000000);
    run_one("sra4", 32'hF000000F, 4, 2'd2, 32'hFF000000);
    run_one("ror4", 32'hF000000F, 4, 2'd3, 32'hFF000000);
    for (int i = 0; i < 4; i++) run_one("shift0", 32'hDEADBEEF, 0, i[1:0], 32'hDEADBEEF);
    run_one("sra31", 32'h80000000, 31, 2'd2, 32'hFFFFFFFF);
    run_one("sll31", 32'h00000001, 31, 2'd0, 32'h80000000);
`ifdef SHIFT_PIPE_STATUS_EN
    run_one("srl_st", 32'h00000003, 2, 2'd1, 32'h00000000);
    chk("srl_st_zero", out_zero, 1);
    chk("srl_st_carry", out_carry, 1);
    run_one("sll_st", 32'h40000000, 1, 2'd0, 32'h80000000);
    chk("sll_st_carry", out_carry, 0);
`endif

    run8("w8_ror1", 8'h81, 1, 2'd3, 32'hC0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d8;
      logic [2:0] s8;
      logic [1:0] o8;
      d8 = 8'($urandom); s8 = 3'($urandom); o8 = 2'($urandom);
      e = model({24'd0, d8}, s8, o8, 8);
      run8("w8_rand", d8, s8, o8, e.d, e.c);
    end

    n0 = n_out;
    @(posedge clock); #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
          b = 0;
          @(negedge clock);
          while (!in_ready && b < 50) begin
            @(negedge clock);
            b++;
          end
          if (b >= 50) chk("bp_accept_timeout", in_ready, 1);
          @(posedge clock); #1;
        end
        in_valid = 0;
      end
      begin
        repeat (3) @(posedge clock);
        #1 out_ready = 0;
        repeat (5) @(negedge clock);
        chk("bp_ready", in_ready, 0);
        chk("bp_inflight", q.size(), 5);
        chk("bp_held_valid", out_valid, 1);
        repeat (5) @(posedge clock);
        #1 out_ready = 1;
      end
    join
    b = 0;
    while (q.size() != 0 && b < 40) begin
      @(negedge clock);
      b++;
    end
    chk("bp_count", n_out - n0, 8);
    chk("bp_drain", q.size(), 0);

    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
      @(posedge clock); #1;
    end
    flush = 1;
    @(negedge clock);
    chk("flush_ready", in_ready, 0);
    @(posedge clock); #1;
    flush = 0; in_valid = 0;
    cnt = 0;
    repeat (10) begin
      @(negedge clock);
      cnt += int'(out_valid);
    end
    chk("flush_none", cnt, 0);

    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
      @(posedge clock); #1;
    end
    in_valid = 0;
    repeat (6) @(negedge clock);
    chk("pre_rst_valid", out_valid, 1);
    @(posedge clock);
    #3 reset_n = 0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_data", out_data, 0);
    @(posedge clock); #1;
    reset_n = 1; out_ready = 1;
    cnt = 0;
    repeat (10) begin
      @(negedge clock);
      cnt += int'(out_valid);
    end
    chk("post_rst_none", cnt, 0);

    for (int i = 0; i < 600; i++) begin
      @(posedge clock); #1;
      in_valid = ($urandom % 4) != 0;
      case ($urandom % 6)
        0: in_data = 32'h0;
        1: in_data = 32'h80000000;
        2: in_data = 32'hFFFFFFFF;
        default: in_data = $urandom;
      endcase
      in_shamt = 5'($urandom);
      in_op = 2'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 60) == 0;
    end
    @(posedge clock); #1;
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (20) @(negedge clock);
    chk("final_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
